instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch-side initiator for the instruction memory (IM, 64K x 16, word addressed).
//  - Owns the fetch PC and drives IM address and read-enable.
//  - Captures IM read data into a small prefetch FIFO of {pc, instr} pairs.
//  - Presents the FIFO head to decode with a valid/ready handshake.
//  - Branch redirect flushes the FIFO and restarts fetch at a new target.
// PARAMETERS
//  DEPTH     4        prefetch FIFO entries; power of two, >= 2
//  RESET_PC  16'h0000 fetch PC loaded by reset
// PORTS
//  clk           in   1   system clock; all state updates on posedge
//  rst_n         in   1   synchronous reset, active low
//  im_addr       out  16  IM word address (= fetch_pc)
//  im_rd_en      out  1   IM read request for im_addr this cycle
//  im_instr      in   16  IM read data; valid at the posedge ending a cycle with im_rd_en=1
//  if_instr      out  16  FIFO head instruction; 16'h0000 when if_valid=0
//  if_pc         out  16  PC of the FIFO head; 16'h0000 when if_valid=0
//  if_valid      out  1   FIFO non-empty
//  if_ready      in   1   decode accepts head; pop = if_valid & if_ready
//  br_taken      in   1   redirect request, single-cycle pulse or level
//  br_target     in   16  redirect PC
//  fetch_halted  out  1   halt detected (see CONFIGURATION); constant 0 otherwise
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): fetch_pc<=RESET_PC, count<=0, rd/wr ptrs<=0, halted<=0.
//    im_rd_en=0 combinationally while rst_n=0. All if_* outputs read 0.
//  - Issue: im_rd_en = rst_n & ~br_taken & ~halted & (count < DEPTH).
//    Issue does not count a same-cycle pop, so no push ever hits a full FIFO.
//  - IM latency: 1 cycle. IM latches on clk low, so im_instr is sampled at the
//    posedge closing the issue cycle. No outstanding requests exist across cycles.
//  - Push at posedge when im_rd_en=1:
//      mem[wr_ptr] <= {fetch_pc, im_instr}
//      fetch_pc    <= fetch_pc + 1, 16-bit wrap (16'hFFFF -> 16'h0000)
//  - Pop at posedge when if_valid & if_ready: rd_ptr advances.
//  - Count update:
//      push & pop  -> unchanged
//      push only   -> +1
//      pop only    -> -1
//  - Pointers are log2(DEPTH) bits and wrap naturally.
//  - Redirect (br_taken=1 at posedge) has priority over push and pop:
//      count<=0, rd_ptr<=wr_ptr, fetch_pc<=br_target, halted<=0
//      no push that cycle (im_rd_en already 0); a same-cycle pop is discarded
//      first fetch from br_target issues the following cycle
//      if_valid is 0 for exactly one cycle after the redirect edge
//  - Head outputs are combinational from mem[rd_ptr], gated by if_valid.
//  - Empty: if_valid=0; if_ready is ignored.
//  - Full: im_rd_en=0 until a pop lowers count.
//  - Reset mid-stream: in-flight data is dropped, FIFO emptied, fetch restarts
//    at RESET_PC on the first cycle with rst_n=1.
// CONFIGURATION
//  HALT_DETECT_EN defined:
//    - A pushed instr with [15:12]==4'hF (HLT) sets halted<=1 at the push edge.
//    - im_rd_en then stays 0; fetch_halted=halted.
//    - Already-queued entries, including the HLT, still drain to decode.
//    - Cleared only by br_taken or reset.
//  HALT_DETECT_EN undefined:
//    - halted is held 0 and fetch_halted=0.
//    - Fetch continues through HLT encodings.
// TESTING
//  1. Reset, IM[0..3]=1111,2222,3333,4444, if_ready=1 -> im_addr 0,1,2,3 on
//     consecutive cycles; if_instr=1111 with if_pc=0 one cycle after the first issue.
//  2. if_ready=0 -> exactly DEPTH=4 pushes, then im_rd_en=0 and im_addr holds 4.
//     Raise if_ready -> im_rd_en returns the next cycle.
//  3. FIFO holding 3 entries, br_taken=1 with br_target=16'h0100 -> if_valid=0 next
//     cycle; next if_pc=0100 and queued entries never appear.
//  4. RESET_PC=16'hFFFE, if_ready=1 -> if_pc sequence FFFE, FFFF, 0000, 0001.
//  5. HALT_DETECT_EN defined, IM[2]=16'hF000 -> fetch_halted=1 after addr 2,
//     addr 3 never issued, F000 delivered. br_taken to 0x10 -> resumes.
//     Without the macro: addr 3 is fetched and fetch_halted stays 0.
//  6. rst_n=0 for one cycle with FIFO full -> if_valid=0 next cycle;
//     im_addr=RESET_PC with im_rd_en=1 on the first cycle with rst_n=1.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues IM reads into a DEPTH-entry
// {pc, instr} prefetch FIFO, and presents the FIFO head to decode. Optional HLT stop: HALT_DETECT_EN.
// Latency: IM data lands in the FIFO at the edge closing the issue cycle; head is combinational.
// Backpressure: fetch stalls while the FIFO is full or halted; a redirect squashes the FIFO.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] im_addr,
    output logic        im_rd_en,
    input  logic [15:0] im_instr,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic        if_valid,
    input  logic        if_ready,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic        fetch_halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     fetch_pc_q, fetch_pc_d;
    logic            halted_q, halted_d;

    logic            push;
    logic            pop;
    logic            is_hlt;

`ifdef HALT_DETECT_EN
    assign is_hlt = (im_instr[15:12] == 4'hF);
`else
    assign is_hlt = 1'b0;
`endif

    // Issue ignores a same-cycle pop, so a push can never land on a full FIFO.
    assign im_rd_en     = rst_n & ~br_taken & ~halted_q & (count_q < CW'(DEPTH));
    assign im_addr      = fetch_pc_q;
    assign if_valid     = rst_n & (count_q != '0);
    assign if_instr     = if_valid ? mem_q[rd_ptr_q].instr : 16'h0000;
    assign if_pc        = if_valid ? mem_q[rd_ptr_q].pc    : 16'h0000;
    assign fetch_halted = halted_q;

    assign push = im_rd_en;
    assign pop  = if_valid & if_ready;

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;

        if (br_taken) begin
            // Redirect discards everything queued, including a same-cycle pop.
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            fetch_pc_d = br_target;
            halted_d   = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: fetch_pc_q, instr: im_instr};
                wr_ptr_d        = wr_ptr_q + 1'b1;
                fetch_pc_d      = fetch_pc_q + 16'd1;
                halted_d        = halted_q | is_hlt;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based fetch model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] im_addr, im_instr, if_instr, if_pc, br_target;
    logic        im_rd_en, if_valid, if_ready, br_taken, fetch_halted;

    logic [15:0] w_im_addr, w_im_instr, w_if_instr, w_if_pc;
    logic        w_im_rd_en, w_if_valid, w_fetch_halted;
    logic        w_if_ready, w_br_taken;
    logic [15:0] w_br_target;

    logic [15:0] im_mem [65536];

    assign im_instr   = im_mem[im_addr];
    assign w_im_instr = im_mem[w_im_addr];

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_rd_en(im_rd_en),
        .im_instr(im_instr), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .if_ready(if_ready), .br_taken(br_taken), .br_target(br_target),
        .fetch_halted(fetch_halted)
    );

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_wrap (
        .clk(clk), .rst_n(rst_n), .im_addr(w_im_addr), .im_rd_en(w_im_rd_en),
        .im_instr(w_im_instr), .if_instr(w_if_instr), .if_pc(w_if_pc), .if_valid(w_if_valid),
        .if_ready(w_if_ready), .br_taken(w_br_taken), .br_target(w_br_target),
        .fetch_halted(w_fetch_halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    logic        m_halted;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] obs_addr, obs_pc, obs_instr, obs_w_pc;
    logic        obs_rd, obs_valid, obs_halted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        logic        e_valid, e_rd;
        logic [15:0] e_pc, e_instr;
        #1;
        e_valid = rst_n && (mq.size() != 0);
        e_rd    = rst_n && !br_taken && !m_halted && (mq.size() < DEPTH);
        e_pc    = e_valid ? mq[0].pc : 16'h0000;
        e_instr = e_valid ? mq[0].instr : 16'h0000;
        chk("im_addr", {16'h0, im_addr}, {16'h0, m_pc});
        chk("im_rd_en", {31'h0, im_rd_en}, {31'h0, e_rd});
        chk("if_valid", {31'h0, if_valid}, {31'h0, e_valid});
        chk("if_pc", {16'h0, if_pc}, {16'h0, e_pc});
        chk("if_instr", {16'h0, if_instr}, {16'h0, e_instr});
        chk("fetch_halted", {31'h0, fetch_halted}, {31'h0, m_halted});
        obs_addr   = im_addr;
        obs_rd     = im_rd_en;
        obs_valid  = if_valid;
        obs_pc     = if_pc;
        obs_instr  = if_instr;
        obs_halted = fetch_halted;
        obs_w_pc   = w_if_pc;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_pc     = 16'h0000;
            m_halted = 1'b0;
        end else if (br_taken) begin
            mq.delete();
            m_pc     = br_target;
            m_halted = 1'b0;
        end else begin
            if (e_valid && if_ready) void'(mq.pop_front());
            if (e_rd) begin
                mq.push_back('{pc: m_pc, instr: im_mem[m_pc]});
`ifdef HALT_DETECT_EN
                if (im_mem[m_pc][15:12] == 4'hF) m_halted = 1'b1;
`endif
                m_pc = m_pc + 16'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        br_taken = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] wrap_exp [4];
        int pushes;
        clk = 1'b0;
        rst_n = 1'b0;
        if_ready = 1'b0;
        br_taken = 1'b0;
        br_target = 16'h0000;
        w_if_ready = 1'b1;
        w_br_taken = 1'b0;
        w_br_target = 16'h0000;
        m_pc = 16'h0000;
        m_halted = 1'b0;
        wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        for (int i = 0; i < 65536; i++) im_mem[i] = 16'($urandom);
        im_mem[0] = 16'h1111;
        im_mem[1] = 16'h2222;
        im_mem[2] = 16'h3333;
        im_mem[3] = 16'h4444;
        @(negedge clk);

        // Sequential fetch after reset; wrap instance exercises PC rollover.
        do_reset();
        chk("rst_valid", {31'h0, obs_valid}, 32'h0);
        chk("rst_rd_en", {31'h0, obs_rd}, 32'h0);
        if_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (k < 4) chk("seq_addr", {16'h0, obs_addr}, k);
            if (k < 4) chk("seq_rd_en", {31'h0, obs_rd}, 32'h1);
            if (k >= 1) chk("wrap_pc", {16'h0, obs_w_pc}, {16'h0, wrap_exp[k-1]});
            if (k == 1) begin
                chk("first_valid", {31'h0, obs_valid}, 32'h1);
                chk("first_instr", {16'h0, obs_instr}, 32'h1111);
                chk("first_pc", {16'h0, obs_pc}, 32'h0);
            end
        end

        // Fill without consuming.
        do_reset();
        if_ready = 1'b0;
        pushes = 0;
        repeat (6) begin
            cycle();
            pushes += int'(obs_rd);
        end
        chk("full_pushes", pushes, DEPTH);
        chk("full_addr", {16'h0, obs_addr}, 32'h4);
        chk("full_rd_en", {31'h0, obs_rd}, 32'h0);
        if_ready = 1'b1;
        cycle();
        chk("pop_cycle_rd_en", {31'h0, obs_rd}, 32'h0);
        cycle();
        chk("resume_rd_en", {31'h0, obs_rd}, 32'h1);

        // Redirect with three queued entries.
        do_reset();
        if_ready = 1'b0;
        repeat (3) cycle();
        br_taken = 1'b1;
        br_target = 16'h0100;
        cycle();
        chk("br_cycle_rd_en", {31'h0, obs_rd}, 32'h0);
        br_taken = 1'b0;
        if_ready = 1'b1;
        cycle();
        chk("br_gap_valid", {31'h0, obs_valid}, 32'h0);
        chk("br_addr", {16'h0, obs_addr}, 32'h0100);
        cycle();
        chk("br_head_valid", {31'h0, obs_valid}, 32'h1);
        chk("br_head_pc", {16'h0, obs_pc}, 32'h0100);

        // HLT encoding at address 2.
        im_mem[2] = 16'hF000;
        do_reset();
        if_ready = 1'b1;
        repeat (3) cycle();
        cycle();
`ifdef HALT_DETECT_EN
        chk("hlt_halted", {31'h0, obs_halted}, 32'h1);
        chk("hlt_rd_en", {31'h0, obs_rd}, 32'h0);
        chk("hlt_instr", {16'h0, obs_instr}, 32'hF000);
        chk("hlt_pc", {16'h0, obs_pc}, 32'h2);
`else
        chk("nohlt_halted", {31'h0, obs_halted}, 32'h0);
        chk("nohlt_rd_en", {31'h0, obs_rd}, 32'h1);
        chk("nohlt_addr", {16'h0, obs_addr}, 32'h3);
`endif
        cycle();
        br_taken = 1'b1;
        br_target = 16'h0010;
        cycle();
        br_taken = 1'b0;
        cycle();
        chk("hlt_resume_rd_en", {31'h0, obs_rd}, 32'h1);
        chk("hlt_resume_addr", {16'h0, obs_addr}, 32'h0010);
        chk("hlt_resume_halted", {31'h0, obs_halted}, 32'h0);

        // Reset with a full FIFO.
        do_reset();
        if_ready = 1'b0;
        repeat (5) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("rst_full_valid", {31'h0, obs_valid}, 32'h0);
        chk("rst_full_addr", {16'h0, obs_addr}, 32'h0);
        chk("rst_full_rd_en", {31'h0, obs_rd}, 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) im_mem[$urandom_range(0, 65535)] = 16'hF000 | 16'($urandom_range(0, 4095));
        for (int n = 0; n < 4000; n++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            br_taken = ($urandom_range(0, 9) == 0);
            br_target = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                                    : 16'($urandom);
            if_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
